// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between an instruction-fetch
// requester and a data-stage requester. Each request runs through
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (one-cycle Ready pulse).
// Data normally wins arbitration. A saturating starvation counter lets fetch
// win once data has been granted STARVE_LIMIT times in a row while fetch waited.
//
// Parameters
//   WAIT_CYCLES   extra memory wait cycles per access (0..7)
//   STARVE_LIMIT  consecutive data grants allowed while fetch is waiting
//
// Ports
//   Clk, Reset                 clock, asynchronous active-low reset
//   IReq, IAddr                fetch request (level) and byte address
//   IRdata, IReady             fetch read data and completion pulse
//   DReq, DWe, DAddr, DWdata   data request, write flag, byte address, write data
//   DRdata, DReady             data read result and completion pulse
//   MemEn, MemWe, MemAddr,
//   MemWdata, MemRdata         shared memory port
//   Busy                       high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IRdata,
    output logic        IReady,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWdata,
    output logic [31:0] DRdata,
    output logic        DReady,
    output logic        MemEn,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LOAD   = 3'(WAIT_CYCLES);
    localparam logic [2:0] STARVE_SAT  = 3'(STARVE_LIMIT);

    state_t      state_q,     state_d;
    logic        g_q,         g_d;          // 0 = fetch owns the access, 1 = data
    logic [2:0]  starve_q,    starve_d;
    logic [2:0]  wait_q,      wait_d;
    logic        mem_en_q,    mem_en_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] irdata_q,    irdata_d;
    logic [31:0] drdata_q,    drdata_d;
    logic        iready_q,    iready_d;
    logic        dready_q,    dready_d;

    logic data_win;
    logic fetch_win;

    // Memory is word addressed; the byte-offset bits are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IAddr[1:0], DAddr[1:0]};

    // Data has priority unless fetch has already waited through the allowed
    // number of back-to-back data grants.
    assign data_win  = DReq && !(IReq && (starve_q == STARVE_SAT));
    assign fetch_win = IReq && !data_win;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        g_d         = g_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        iready_d    = 1'b0;
        dready_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_win || fetch_win) begin
                    state_d     = ACCESS;
                    g_d         = data_win;
                    wait_d      = WAIT_LOAD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = data_win && DWe;
                    mem_addr_d  = data_win ? {DAddr[31:2], 2'b00} : {IAddr[31:2], 2'b00};
                    mem_wdata_d = data_win ? DWdata : 32'h0;
                end

                // Counts only data grants that made a waiting fetch wait longer.
                if (fetch_win || !IReq) begin
                    starve_d = 3'd0;
                end else if (data_win && (starve_q != STARVE_SAT)) begin
                    starve_d = starve_q + 3'd1;
                end
            end

            ACCESS: begin
                if (wait_q == 3'd0) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    // mem_we_q can only be set for a data grant, so it doubles
                    // as "this access was a write".
                    if (!mem_we_q) begin
                        if (g_q) drdata_d = MemRdata;
                        else     irdata_d = MemRdata;
                    end
                    if (g_q) dready_d = 1'b1;
                    else     iready_d = 1'b1;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            g_q         <= 1'b0;
            starve_q    <= 3'd0;
            wait_q      <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            irdata_q    <= 32'h0;
            drdata_q    <= 32'h0;
            iready_q    <= 1'b0;
            dready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            iready_q    <= iready_d;
            dready_q    <= dready_d;
        end
    end

    assign MemEn    = mem_en_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign IRdata   = irdata_q;
    assign DRdata   = drdata_q;
    assign IReady   = iready_q;
    assign DReady   = dready_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. The main instance uses the default
// parameters; a second instance with WAIT_CYCLES=0 shares the address/data
// inputs and the memory read bus but has its own request lines.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        Clk;
    logic        Reset;
    logic        IReq;
    logic [31:0] IAddr;
    logic        DReq;
    logic        DWe;
    logic [31:0] DAddr;
    logic [31:0] DWdata;
    logic [31:0] MemRdata;

    logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
    logic        IReady, DReady, MemEn, MemWe, Busy;

    logic        i0_req;
    logic        d0_req;
    logic [31:0] irdata0, drdata0, mem_addr0, mem_wdata0;
    logic        iready0, dready0, mem_en0, mem_we0, busy0;

    int pass_cnt  = 0;
    int check_cnt = 0;

    mem_arbiter dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IRdata   (IRdata),
        .IReady   (IReady),
        .DReq     (DReq),
        .DWe      (DWe),
        .DAddr    (DAddr),
        .DWdata   (DWdata),
        .DRdata   (DRdata),
        .DReady   (DReady),
        .MemEn    (MemEn),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemRdata (MemRdata),
        .Busy     (Busy)
    );

    mem_arbiter #(.WAIT_CYCLES(0), .STARVE_LIMIT(2)) dut0 (
        .Clk      (Clk),
        .Reset    (Reset),
        .IReq     (i0_req),
        .IAddr    (IAddr),
        .IRdata   (irdata0),
        .IReady   (iready0),
        .DReq     (d0_req),
        .DWe      (DWe),
        .DAddr    (DAddr),
        .DWdata   (DWdata),
        .DRdata   (drdata0),
        .DReady   (dready0),
        .MemEn    (mem_en0),
        .MemWe    (mem_we0),
        .MemAddr  (mem_addr0),
        .MemWdata (mem_wdata0),
        .MemRdata (MemRdata),
        .Busy     (busy0)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    initial begin
        int n;
        Reset    = 1'b1;
        IReq     = 1'b0;
        IAddr    = 32'h0;
        DReq     = 1'b0;
        DWe      = 1'b0;
        DAddr    = 32'h0;
        DWdata   = 32'h0;
        MemRdata = 32'h0;
        i0_req   = 1'b0;
        d0_req   = 1'b0;

        // ---------------- reset state ----------------
        #1 Reset = 1'b0;
        #2;
        check("rst_mem_en",    MemEn,    0);
        check("rst_mem_we",    MemWe,    0);
        check("rst_mem_addr",  MemAddr,  0);
        check("rst_mem_wdata", MemWdata, 0);
        check("rst_irdata",    IRdata,   0);
        check("rst_drdata",    DRdata,   0);
        check("rst_iready",    IReady,   0);
        check("rst_dready",    DReady,   0);
        check("rst_busy",      Busy,     0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("idle_no_req_busy", Busy, 0);

        // ---------------- fetch only ----------------
        IReq = 1'b1; IAddr = 32'h0000_0104; MemRdata = 32'h2008_0005;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            check("f_mem_en",   MemEn,   1);
            check("f_mem_addr", MemAddr, 32'h104);
            check("f_mem_we",   MemWe,   0);
            check("f_busy",     Busy,    1);
            check("f_iready_early", IReady, 0);
        end
        check("f_irdata_before_capture", IRdata, 0);
        @(negedge Clk);  // t+4
        check("f_iready",    IReady, 1);
        check("f_dready",    DReady, 0);
        check("f_irdata",    IRdata, 32'h2008_0005);
        check("f_resp_men",  MemEn,  0);
        IReq = 1'b0;
        @(negedge Clk);
        check("f_iready_pulse_end", IReady, 0);
        check("f_busy_end",         Busy,   0);

        // ---------------- data write ----------------
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'h0000_0013; DWdata = 32'hDEAD_BEEF;
        MemRdata = 32'h1234_5678;
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            check("w_mem_en",    MemEn,    1);
            check("w_mem_we",    MemWe,    1);
            check("w_mem_addr",  MemAddr,  32'h10);
            check("w_mem_wdata", MemWdata, 32'hDEAD_BEEF);
        end
        @(negedge Clk);
        check("w_dready",  DReady, 1);
        check("w_iready",  IReady, 0);
        check("w_drdata",  DRdata, 0);
        check("w_irdata",  IRdata, 32'h2008_0005);
        check("w_resp_we", MemWe,  0);
        DReq = 1'b0; DWe = 1'b0;
        @(negedge Clk);
        check("w_dready_end", DReady, 0);
        check("w_mem_en_end", MemEn,  0);

        // ---------------- simultaneous requests ----------------
        IReq = 1'b1; IAddr = 32'h0000_0200;
        DReq = 1'b1; DAddr = 32'h0000_0300; MemRdata = 32'hAAAA_0001;
        @(negedge Clk);
        check("s_first_is_data", MemAddr, 32'h300);
        check("s_first_we",      MemWe,   0);
        repeat (2) begin
            @(negedge Clk);
            check("s_no_ready_i", IReady, 0);
            check("s_no_ready_d", DReady, 0);
        end
        @(negedge Clk);
        check("s_dready",  DReady, 1);
        check("s_iready0", IReady, 0);
        check("s_drdata",  DRdata, 32'hAAAA_0001);
        check("s_irdata_kept", IRdata, 32'h2008_0005);
        DReq = 1'b0; MemRdata = 32'hBBBB_0002;
        @(negedge Clk);
        check("s_idle_gap", Busy, 0);
        @(negedge Clk);
        check("s_second_is_fetch", MemAddr, 32'h200);
        repeat (2) @(negedge Clk);
        @(negedge Clk);
        check("s_iready",  IReady, 1);
        check("s_dready0", DReady, 0);
        check("s_irdata",  IRdata, 32'hBBBB_0002);
        check("s_drdata_kept", DRdata, 32'hAAAA_0001);
        IReq = 1'b0;
        @(negedge Clk);

        // ---------------- starvation ----------------
        IReq = 1'b1; IAddr = 32'h0000_0400;
        DReq = 1'b1; DAddr = 32'h0000_0500; MemRdata = 32'hCCCC_0003;
        for (int g = 0; g < 4; g++) begin
            logic [31:0] exp_addr;
            logic        exp_fetch;
            exp_fetch = (g == 2);
            exp_addr  = exp_fetch ? 32'h400 : 32'h500;
            n = 0;
            do begin @(negedge Clk); n++; end while (!MemEn && n < 10);
            check("st_grant_seen", MemEn, 1);
            check("st_grant_addr", MemAddr, exp_addr);
            n = 0;
            do begin @(negedge Clk); n++; end while (!(IReady || DReady) && n < 10);
            check("st_iready", IReady, exp_fetch);
            check("st_dready", DReady, !exp_fetch);
            if (g == 3) begin
                IReq = 1'b0; DReq = 1'b0;
            end
        end
        @(negedge Clk);
        check("st_end_idle", Busy, 0);

        // ---------------- reset mid-ACCESS ----------------
        IReq = 1'b1; IAddr = 32'h0000_0104; MemRdata = 32'h1111_2222;
        @(negedge Clk);
        check("r_access1", MemEn, 1);
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        check("r_mem_en",   MemEn,   0);
        check("r_mem_addr", MemAddr, 0);
        check("r_busy",     Busy,    0);
        check("r_irdata",   IRdata,  0);
        check("r_drdata",   DRdata,  0);
        check("r_iready",   IReady,  0);
        IReq = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            check("r_no_pulse", IReady, 0);
        end
        Reset = 1'b1; IReq = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            check("r2_no_early_ready", IReady, 0);
        end
        @(negedge Clk);
        check("r2_iready", IReady, 1);
        check("r2_irdata", IRdata, 32'h1111_2222);
        IReq = 1'b0;
        @(negedge Clk);
        check("r2_busy_end", Busy, 0);

        // ---------------- WAIT_CYCLES = 0 ----------------
        i0_req = 1'b1; IAddr = 32'h0000_0040; MemRdata = 32'h0BAD_F00D;
        @(negedge Clk);
        check("z_mem_en",   mem_en0,   1);
        check("z_mem_addr", mem_addr0, 32'h40);
        check("z_no_ready", iready0,   0);
        @(negedge Clk);
        check("z_iready",   iready0, 1);
        check("z_irdata",   irdata0, 32'h0BAD_F00D);
        check("z_mem_en_off", mem_en0, 0);
        i0_req = 1'b0;
        @(negedge Clk);
        check("z_iready_end", iready0, 0);
        check("z_busy_end",   busy0,   0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning extra memory wait cycles per access (legal 0..7).
REQ-002 SHALL have parameter STARVE_LIMIT, default 2, meaning consecutive data grants allowed while fetch waits.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports IReq input 1 (fetch request, level) and IAddr input 32 (fetch byte address).
REQ-006 SHALL have ports IRdata output 32 (fetch read data) and IReady output 1 (fetch completion pulse).
REQ-007 SHALL have ports DReq input 1, DWe input 1 (1 = write), DAddr input 32 and DWdata input 32 (data-stage request).
REQ-008 SHALL have ports DRdata output 32 (data read result) and DReady output 1 (data completion pulse).
REQ-009 SHALL have ports MemEn output 1, MemWe output 1, MemAddr output 32, MemWdata output 32 and MemRdata input 32 (shared single-port memory).
REQ-010 SHALL have port Busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS and RESP, plus a registered grant bit G (0 = fetch, 1 = data).
REQ-012 In IDLE with any request present, SHALL latch the winner's address, write data and write flag, set G and go to ACCESS next cycle; with no request SHALL stay in IDLE.
REQ-013 Arbitration: data wins over fetch unless IReq is high and the starvation counter equals STARVE_LIMIT, in which case fetch wins.
REQ-014 Starvation counter (3 bits): +1 on each data grant made while IReq is high; cleared on any fetch grant or when IReq is low in IDLE; saturates at STARVE_LIMIT.
REQ-015 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, tracked by a down-counter loaded with WAIT_CYCLES on entry; MemEn=1 and MemAddr/MemWdata/MemWe SHALL stay stable for the whole of ACCESS.
REQ-016 MemAddr SHALL equal the latched address with bits [1:0] forced to 0; MemWe SHALL equal the latched DWe only when G=1, otherwise 0.
REQ-017 On the last ACCESS cycle of a read, SHALL capture MemRdata into IRdata (G=0) or DRdata (G=1); the other data output SHALL be unchanged.
REQ-018 RESP SHALL last one cycle and pulse IReady (G=0) or DReady (G=1); the next state SHALL be IDLE.
REQ-019 Latency: request sampled in IDLE at cycle t gives a Ready pulse at cycle t+2+WAIT_CYCLES (t+4 at default).
REQ-020 IRdata/DRdata SHALL hold their value until the next capture for the same requester.
REQ-021 A data write SHALL still pulse DReady and SHALL leave DRdata unchanged.
REQ-022 Requesters hold Req and their address/data stable until Ready; Req still high in the IDLE cycle after RESP SHALL be arbitrated as a new request.
REQ-023 Changes to request inputs during ACCESS/RESP SHALL be ignored.
REQ-024 Outside ACCESS, MemEn and MemWe SHALL be 0.
REQ-025 IReady and DReady SHALL never be high in the same cycle.

Reset
REQ-026 Reset low SHALL immediately force the state to IDLE, G=0, counters=0, MemEn=MemWe=0, MemAddr=MemWdata=0, IRdata=DRdata=0, IReady=DReady=0 and Busy=0.
REQ-027 Reset asserted mid-ACCESS SHALL abandon the access with no Ready pulse; operation SHALL resume from IDLE on the first edge after release.

Verification
REQ-028 Fetch only: IReq=1, IAddr=0x0000_0104, MemRdata=0x2008_0005 -> MemEn high for 3 cycles with MemAddr=0x104; IReady pulses at t+4 with IRdata=0x2008_0005.
REQ-029 Simultaneous requests (IReq=DReq=1) -> data granted first; fetch granted in the next IDLE; at most two Ready pulses, never in the same cycle.
REQ-030 Starvation: DReq held high with the data requester re-requesting each time, IReq held high -> exactly 2 data grants, then a fetch grant, then the counter reads 0.
REQ-031 Write: DReq=1, DWe=1, DAddr=0x0000_0013, DWdata=0xDEAD_BEEF -> MemWe=1, MemAddr=0x10, MemWdata=0xDEAD_BEEF for 3 cycles; DReady pulses; DRdata unchanged.
REQ-032 Reset pulled low during the 2nd ACCESS cycle -> all outputs 0 at once; no Ready pulse; a fresh IReq after release completes in 4 cycles.
REQ-033 WAIT_CYCLES=0 -> ACCESS lasts 1 cycle and Ready pulses at t+2.
